// File: rtl/calc_ctrl_pkg.sv
// Shared encodings and defaults for the calc/div/mult sequencing controller.
// The FSM and its wait counter both import this package.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;

  localparam logic       SEL_H_DIV  = 1'b0;
  localparam logic       SEL_H_MULT = 1'b1;
  localparam logic [1:0] SEL_L_CALC = 2'b00;
  localparam logic [1:0] SEL_L_DIV  = 2'b01;
  localparam logic [1:0] SEL_L_MULT = 2'b10;
  localparam logic [1:0] SEL_L_ZERO = 2'b11;

  localparam int DEF_MULT_LAT = 4;
  localparam int DEF_TIMEOUT  = 32;

  // Codes 110 and 111 are the only illegal operations.
  function automatic logic op_legal(input logic [2:0] o);
    return o[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/cu_wait_cnt.sv
// 8-bit wait-cycle counter with synchronous clear, count enable and a
// terminal-match flag compared against a caller-supplied terminal value.
module cu_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] term,
  output logic       match
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= 8'd0;
    end else if (en) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign match = (count_reg == term);

endmodule

// File: rtl/calc_ctrl.sv
// Sequencing FSM for a calc/div/mult datapath: loads operands, starts one unit,
// waits for completion (or a fixed multiplier latency / timeout) and captures.
module calc_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] op,
  input  logic       done_calc,
  input  logic       done_div,
  output logic       en_x,
  output logic       en_y,
  output logic       go_calc,
  output logic       go_div,
  output logic       go_mult,
  output logic [1:0] op_calc,
  output logic       sel_h,
  output logic [1:0] sel_l,
  output logic       en_out_h,
  output logic       en_out_l,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] cs
);

  state_t     state_reg, state_next;
  logic [2:0] op_reg, op_next;
  logic       err_reg, err_next;
  logic       cnt_clr, cnt_en, cnt_match;
  logic [7:0] cnt_term;
  logic       is_calc, is_div, is_mult, done_hit;

  assign is_calc  = ~op_reg[2];
  assign is_div   = (op_reg == OP_DIV);
  assign is_mult  = (op_reg == OP_MULT);
  assign done_hit = (is_calc & done_calc) | (is_div & done_div);

  // One counter serves both the multiplier latency and the completion timeout.
  assign cnt_term = is_mult ? 8'(MULT_LAT - 1) : 8'(TIMEOUT - 1);

  cu_wait_cnt u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .match (cnt_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= 3'b000;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    err_next   = err_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    en_x       = 1'b0;
    en_y       = 1'b0;
    go_calc    = 1'b0;
    go_div     = 1'b0;
    go_mult    = 1'b0;
    op_calc    = 2'b00;
    sel_h      = 1'b0;
    sel_l      = SEL_L_ZERO;
    en_out_h   = 1'b0;
    en_out_l   = 1'b0;
    busy       = (state_reg != ST_IDLE);
    done       = 1'b0;
    err        = err_reg;
    cs         = state_reg;

    case (state_reg)
      ST_IDLE: begin
        if (go) begin
          err_next = ~op_legal(op);
          if (op_legal(op)) begin
            op_next    = op;
            state_next = ST_LOAD;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        en_x       = 1'b1;
        en_y       = 1'b1;
        state_next = ST_START;
      end
      ST_START: begin
        go_calc    = is_calc;
        go_div     = is_div;
        go_mult    = is_mult;
        op_calc    = op_reg[1:0];
        cnt_clr    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        go_mult = is_mult;
        op_calc = op_reg[1:0];
        cnt_en  = 1'b1;
        if (is_mult) begin
          if (cnt_match) state_next = ST_CAPTURE;
        end else if (done_hit) begin
          // A done on the final timeout cycle still wins over the abort.
          state_next = ST_CAPTURE;
        end else if (cnt_match) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        op_calc  = op_reg[1:0];
        en_out_l = 1'b1;
        en_out_h = ~is_calc;
        if (is_mult) begin
          sel_h = SEL_H_MULT;
          sel_l = SEL_L_MULT;
        end else if (is_div) begin
          sel_h = SEL_H_DIV;
          sel_l = SEL_L_DIV;
        end else begin
          sel_l = SEL_L_CALC;
        end
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: stimulus pushes the expected transaction,
// a monitor accumulates pulses per operation and checks them at each done.
module tb_calc_ctrl;

  localparam int ML = 4;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       rst, go, done_calc, done_div;
  logic [2:0] op;
  logic       en_x, en_y, go_calc, go_div, go_mult;
  logic [1:0] op_calc, sel_l;
  logic       sel_h, en_out_h, en_out_l, busy, done, err;
  logic [2:0] cs;

  calc_ctrl #(.MULT_LAT(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op),
    .done_calc(done_calc), .done_div(done_div),
    .en_x(en_x), .en_y(en_y), .go_calc(go_calc), .go_div(go_div), .go_mult(go_mult),
    .op_calc(op_calc), .sel_h(sel_h), .sel_l(sel_l),
    .en_out_h(en_out_h), .en_out_l(en_out_l),
    .busy(busy), .done(done), .err(err), .cs(cs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int done_c; int err; int n_en;
    int n_gc; int n_gd; int n_gm;
    int n_ol; int n_oh;
    int sel_h; int sel_l; int op_c;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  // Monitor: per-operation pulse accumulation, compared when done appears.
  int a_ex, a_ey, a_gc, a_gd, a_gm, a_ol, a_oh, c_sh, c_sl, c_op;
  always @(negedge clk) begin
    if (!busy) begin
      a_ex = 0; a_ey = 0; a_gc = 0; a_gd = 0; a_gm = 0; a_ol = 0; a_oh = 0;
      c_sh = 0; c_sl = 0; c_op = 0;
    end else begin
      a_ex += int'(en_x); a_ey += int'(en_y);
      a_gc += int'(go_calc); a_gd += int'(go_div); a_gm += int'(go_mult);
      a_ol += int'(en_out_l); a_oh += int'(en_out_h);
      if (en_out_l) begin
        c_sh = int'(sel_h); c_sl = int'(sel_l); c_op = int'(op_calc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          me = sb.pop_front();
          $display("txn: done at cycle %0d err=%0d en_x=%0d go_c/d/m=%0d/%0d/%0d out_l/h=%0d/%0d",
                   cyc, err, a_ex, a_gc, a_gd, a_gm, a_ol, a_oh);
          chk("done_cycle", cyc, me.done_c);
          chk("err", err, me.err);
          chk("cs_done", cs, 5);
          chk("en_x_pulses", a_ex, me.n_en);
          chk("en_y_pulses", a_ey, me.n_en);
          chk("go_calc_cycles", a_gc, me.n_gc);
          chk("go_div_cycles", a_gd, me.n_gd);
          chk("go_mult_cycles", a_gm, me.n_gm);
          chk("en_out_l_cycles", a_ol, me.n_ol);
          chk("en_out_h_cycles", a_oh, me.n_oh);
          if (me.n_ol > 0) begin
            chk("cap_sel_h", c_sh, me.sel_h);
            chk("cap_sel_l", c_sl, me.sel_l);
            chk("cap_op_calc", c_op, me.op_c);
          end
        end
      end
    end
  end

  // dw: WAIT cycles before the matching done (-1 = never); noise drives
  // done inputs that must be ignored (wrong unit, outside WAIT, multiply).
  task automatic run(input logic [2:0] o, input int dw, input bit noise);
    exp_t e;
    int g, c;
    bit fin;
    @(negedge clk);
    go = 1'b1; op = o;
    @(posedge clk); #1;
    g = cyc; go = 1'b0; op = 3'b110;
    e = '{default: 0};
    if (o[2:1] == 2'b11) begin
      e.done_c = g; e.err = 1;
    end else if (o == 3'b101) begin
      e.done_c = g + 3 + ML; e.n_en = 1; e.n_gm = 1 + ML;
      e.n_ol = 1; e.n_oh = 1; e.sel_h = 1; e.sel_l = 2; e.op_c = 1;
    end else begin
      e.n_en = 1;
      if (o[2]) e.n_gd = 1; else e.n_gc = 1;
      if (dw < 0) begin
        e.done_c = g + 2 + TO; e.err = 1;
      end else begin
        e.done_c = g + 4 + dw; e.n_ol = 1; e.n_oh = int'(o[2]);
        e.sel_l = o[2] ? 1 : 0; e.op_c = int'(o[1:0]);
      end
    end
    sb.push_back(e);
    fin = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk);
      c = cyc; done_calc = 1'b0; done_div = 1'b0;
      if (!busy) fin = 1'b1;
      else if (o[2:1] != 2'b11) begin
        if (o != 3'b101 && dw >= 0 && c == g + 2 + dw) begin
          if (o[2]) done_div = 1'b1; else done_calc = 1'b1;
        end else if (noise) begin
          if (o == 3'b101 || c == g || (dw >= 0 && c > g + 2 + dw)) begin
            done_calc = 1'b1; done_div = 1'b1;
          end else if (o[2]) done_calc = 1'b1;
          else done_div = 1'b1;
        end
      end
    end
    done_calc = 1'b0; done_div = 1'b0;
    if (!fin) chk("run_completes", 0, 1);
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_cs"}, cs, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err, 0);
    chk({p, "_en_xy"}, {en_x, en_y}, 0);
    chk({p, "_go"}, {go_calc, go_div, go_mult}, 0);
    chk({p, "_en_out"}, {en_out_h, en_out_l}, 0);
    chk({p, "_sel"}, {sel_h, sel_l}, 3);
    chk({p, "_op_calc"}, op_calc, 0);
  endtask

  initial begin
    int g;
    bit hit;
    rst = 1'b1; go = 1'b0; op = 3'b000; done_calc = 1'b0; done_div = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    run(3'b001, 0, 1'b0);   // calc, done in first WAIT cycle
    run(3'b101, 0, 1'b1);   // multiply, stray dones ignored
    run(3'b100, 2, 1'b1);   // divide, done on third WAIT cycle
    run(3'b010, 1, 1'b1);   // calc with wrong-unit noise
    run(3'b100, -1, 1'b0);  // divide timeout
    chk("timeout_err_hold", err, 1);
    chk("timeout_back_idle", cs, 0);
    run(3'b100, TO - 1, 1'b0);  // done on the final timeout cycle wins
    run(3'b111, 0, 1'b0);   // illegal op
    repeat (3) @(negedge clk);
    chk("illegal_err_hold", err, 1);
    chk("illegal_idle", cs, 0);
    run(3'b110, 0, 1'b0);
    run(3'b011, 0, 1'b0);   // legal op clears err

    // Reset in the middle of a divide, with go pulses while busy.
    @(negedge clk);
    go = 1'b1; op = 3'b100;
    @(posedge clk); #1;
    g = cyc; go = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      if (cyc == g + 4) hit = 1'b1;
    end
    chk("reached_wait", hit, 1);
    go = 1'b1; op = 3'b000;
    @(negedge clk);
    go = 1'b0;
    chk("go_ignored_in_wait", cs, 3);
    chk("busy_in_wait", busy, 1);
    rst = 1'b1; go = 1'b1; op = 3'b001; done_div = 1'b1;
    @(negedge clk);
    rst = 1'b0; go = 1'b0; done_div = 1'b0;
    chk_idle("midrst");
    @(negedge clk);
    chk("post_rst_idle", cs, 0);
    run(3'b000, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4: fixed multiplier pipeline latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 32: maximum number of WAIT cycles before abort, legal range 2..255.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port go  in  1  request to start one operation.
REQ-006 SHALL have port op  in  3  operation code: 000-011 = calc ops (passed out as op_calc), 100 = divide, 101 = multiply, 110/111 = illegal.
REQ-007 SHALL have ports done_calc and done_div  in  1 each  completion inputs from the datapath.
REQ-008 SHALL have ports en_x and en_y  out  1 each  operand register load enables.
REQ-009 SHALL have ports go_calc, go_div and go_mult  out  1 each  datapath unit starts.
REQ-010 SHALL have port op_calc  out  2  calc operation.
REQ-011 SHALL have port sel_h  out  1  out_h source: 0 = div remainder, 1 = mult high.
REQ-012 SHALL have port sel_l  out  2  out_l source: 00 = calc, 01 = div quotient, 10 = mult low, 11 = zero.
REQ-013 SHALL have ports en_out_h and en_out_l  out  1 each  result register enables.
REQ-014 SHALL have ports busy, done and err  out  1 each  status outputs.
REQ-015 SHALL have port cs  out  3  current state encoding, for debug.

Function
REQ-016 SHALL implement states IDLE=0, LOAD=1, START=2, WAIT=3, CAPTURE=4, DONE=5; codes 6 and 7 SHALL go to IDLE.
REQ-017 IDLE: go=1 with a legal op SHALL latch op internally and move to LOAD; go=1 with an illegal op SHALL move directly to DONE with err=1.
REQ-018 go SHALL be ignored in every state except IDLE; busy SHALL be 1 in every state except IDLE.
REQ-019 LOAD: en_x=en_y=1 for exactly one cycle, then move to START.
REQ-020 START: exactly one one-cycle pulse on go_calc, go_div or go_mult, selected by the latched op; then move to WAIT and clear the wait counter.
REQ-021 op_calc SHALL equal latched op[1:0] from START until leaving CAPTURE.
REQ-022 WAIT (calc/div): leave for CAPTURE in the cycle done_calc or done_div (matching the op) is sampled high; done inputs SHALL be ignored outside WAIT and for the non-matching unit.
REQ-023 WAIT (mult): go_mult SHALL stay high throughout WAIT; leave for CAPTURE when the counter reaches MULT_LAT-1; done inputs SHALL be ignored.
REQ-024 Timeout: if the counter reaches TIMEOUT-1 without a matching done, move to DONE with err=1 and no CAPTURE; a done arriving in that same cycle SHALL take priority (go to CAPTURE, err=0).
REQ-025 CAPTURE: one cycle. Calc: sel_l=00, en_out_l=1, en_out_h=0. Div: sel_h=0, sel_l=01, both enables 1. Mult: sel_h=1, sel_l=10, both enables 1.
REQ-026 Outside CAPTURE: en_out_h=en_out_l=0 and sel_l=11.
REQ-027 DONE: done=1 for exactly one cycle, then move to IDLE.
REQ-028 err SHALL hold its value until the next accepted go, which SHALL clear it.
REQ-029 Latency SHALL be go sampled at edge k -> done high in cycle k+5 for a calc/div whose done arrives in the first WAIT cycle, and in cycle k+4+MULT_LAT for a multiply.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from go/done inputs to outputs.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, clear the counter and latched op, and set all outputs to 0 (sel_l=11) from the next cycle, including mid-operation.
REQ-032 rst SHALL dominate go and done in the same cycle.

Structure
REQ-033 Package calc_ctrl_pkg SHALL hold the state encodings, op codes, sel_h/sel_l encodings and default parameter values.
REQ-034 The wait counter SHALL be a sub-module cu_wait_cnt (8-bit, synchronous clear, enable, terminal-match output); the FSM SHALL stay in calc_ctrl.

Verification
REQ-035 op=001, go at edge 0, done_calc in the first WAIT cycle -> en_x/en_y at cycle 1, go_calc at cycle 2, en_out_l only at cycle 4, done=1 at cycle 5, err=0.
REQ-036 op=101, MULT_LAT=4 -> go_mult high cycles 2-6, CAPTURE with sel_h=1/sel_l=10 at cycle 7, done at cycle 8.
REQ-037 op=100, done_div never asserted, TIMEOUT=32 -> done=1 with err=1, no en_out_* pulse, back in IDLE afterwards.
REQ-038 op=111 -> done=1 the cycle after go, err=1, no en_x/en_y/go_* activity; next legal go clears err.
REQ-039 rst asserted during WAIT of a divide, plus go pulses while busy -> outputs are 0 the next cycle, go pulses while busy are ignored, and a subsequent op=000 run completes normally.
